decode_stage: RTL and testbench

- Pipelined ALU-class instruction decoder for the RV32 core, between fetch and register-read/execute.
- Decodes R-type (OP) and, when enabled, I-type (OP-IMM) and M-extension instructions into register indices, immediate, ALU op code and control flags.
- Uses valid/ready handshakes on both sides, a registered output, a 1-entry skid buffer, a flush input, an illegal-instruction flag and a saturating illegal counter.

---
 rtl/decode_stage.sv | 184 ++++++++++++++++++
 tb/tb_decode_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32 ALU-class decode stage: decodes OP / OP-IMM / M-extension instructions into a
// registered bundle behind valid/ready handshakes, with a one-entry skid buffer.
module decode_stage #(
    parameter int ENABLE_ITYPE = 1,
    parameter int ENABLE_M     = 0,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [31:0]      imm,
    output logic             use_imm,
    output logic [4:0]       alu_op,
    output logic             reg_write,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam int BW = 55;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_XOR  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_SLL  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_SLT  = 5'd8;
    localparam logic [4:0] OP_SLTU = 5'd9;
    localparam logic [4:0] OP_MUL  = 5'd10;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // funct3 -> op for the funct7=0 register ops; I-type arithmetic shares this mapping
    function automatic logic [4:0] baseOp(input logic [2:0] f3);
        case (f3)
            3'b000:  baseOp = OP_ADD;
            3'b001:  baseOp = OP_SLL;
            3'b010:  baseOp = OP_SLT;
            3'b011:  baseOp = OP_SLTU;
            3'b100:  baseOp = OP_XOR;
            3'b101:  baseOp = OP_SRL;
            3'b110:  baseOp = OP_OR;
            default: baseOp = OP_AND;
        endcase
    endfunction

    logic [6:0]    w_opcode;
    logic [2:0]    w_funct3;
    logic [6:0]    w_funct7;
    logic          w_illegal;
    logic          w_useImm;
    logic [4:0]    w_aluOp;
    logic [31:0]   w_imm;
    logic [BW-1:0] w_decBundle;
    logic          w_accept;
    logic          w_drain;

    logic          r_outValid;
    logic          r_skidFull;
    logic [BW-1:0] r_outBundle;
    logic [BW-1:0] r_skidBundle;
    logic [CNT_W-1:0] r_illegalCount;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];

    always_comb begin
        w_illegal = 1'b0;
        w_useImm  = 1'b0;
        w_aluOp   = OP_ADD;
        w_imm     = '0;
        case (w_opcode)
            OPC_OP: begin
                if (w_funct7 == 7'b0000000)
                    w_aluOp = baseOp(w_funct3);
                else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000)
                    w_aluOp = OP_SUB;
                else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101)
                    w_aluOp = OP_SRA;
                else if (w_funct7 == 7'b0000001 && ENABLE_M != 0)
                    w_aluOp = OP_MUL + {2'b00, w_funct3};
                else
                    w_illegal = 1'b1;
            end
            OPC_OPIMM: begin
                w_useImm = 1'b1;
                if (ENABLE_ITYPE == 0) begin
                    w_illegal = 1'b1;
                end else if (w_funct3 == 3'b001) begin
                    w_aluOp = OP_SLL;
                    w_imm   = {27'd0, in_instr[24:20]};
                    if (w_funct7 != 7'b0000000)
                        w_illegal = 1'b1;
                end else if (w_funct3 == 3'b101) begin
                    w_imm = {27'd0, in_instr[24:20]};
                    if (w_funct7 == 7'b0000000)
                        w_aluOp = OP_SRL;
                    else if (w_funct7 == 7'b0100000)
                        w_aluOp = OP_SRA;
                    else
                        w_illegal = 1'b1;
                end else begin
                    w_aluOp = baseOp(w_funct3);
                    w_imm   = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            default: w_illegal = 1'b1;
        endcase
        // Illegal instructions present a neutral bundle; only the raw register fields survive
        if (w_illegal) begin
            w_aluOp  = OP_ADD;
            w_imm    = '0;
            w_useImm = 1'b0;
        end
    end

    assign w_decBundle = {w_illegal, !w_illegal, w_aluOp, w_useImm, w_imm,
                          in_instr[11:7], in_instr[19:15], in_instr[24:20]};

    assign in_ready = !r_skidFull;
    assign w_accept = in_valid && !r_skidFull;
    assign w_drain  = r_outValid && out_ready;

    // Output register refills from the skid first so ordering is preserved
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid   <= 1'b0;
            r_skidFull   <= 1'b0;
            r_outBundle  <= '0;
            r_skidBundle <= '0;
        end else if (flush) begin
            r_outValid <= 1'b0;
            r_skidFull <= 1'b0;
        end else if (!r_outValid || out_ready) begin
            if (r_skidFull) begin
                r_outBundle <= r_skidBundle;
                r_outValid  <= 1'b1;
                r_skidFull  <= 1'b0;
            end else if (w_accept) begin
                r_outBundle <= w_decBundle;
                r_outValid  <= 1'b1;
            end else begin
                r_outValid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skidBundle <= w_decBundle;
            r_skidFull   <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_illegalCount <= '0;
        else if (!flush && w_drain && r_outBundle[54] && r_illegalCount != CNT_MAX)
            r_illegalCount <= r_illegalCount + CNT_ONE;
    end

    assign out_valid     = r_outValid;
    assign illegal       = r_outBundle[54];
    assign reg_write     = r_outBundle[53];
    assign alu_op        = r_outBundle[52:48];
    assign use_imm       = r_outBundle[47];
    assign imm           = r_outBundle[46:15];
    assign rd            = r_outBundle[14:10];
    assign rs1           = r_outBundle[9:5];
    assign rs2           = r_outBundle[4:0];
    assign illegal_count = r_illegalCount;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two configurations share one input stream and are compared
// against a queue-based reference of the decode rules and handshake occupancy.
module tb_decode_stage;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic [31:0] in_instr;
    logic flush;
    logic out_ready;

    logic aInReady, aOutValid, aUseImm, aRegWrite, aIllegal;
    logic [4:0] aRd, aRs1, aRs2, aAluOp;
    logic [31:0] aImm;
    logic [CNT_W-1:0] aCount;
    logic bInReady, bOutValid, bUseImm, bRegWrite, bIllegal;
    logic [4:0] bRd, bRs1, bRs2, bAluOp;
    logic [31:0] bImm;
    logic [CNT_W-1:0] bCount;
    logic [54:0] aBundle, bBundle;

    int checkCount = 0;
    int passCount = 0;
    logic [31:0] q[$];
    logic [CNT_W-1:0] cntA, cntB;
    int baseOps[8] = '{0, 5, 8, 9, 2, 6, 3, 4};

    always #5 clk = ~clk;

    // A: full ISA (I-type and M enabled); B: R-type base only
    decode_stage #(.ENABLE_ITYPE(1), .ENABLE_M(1), .CNT_W(CNT_W)) dutA (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(aInReady), .in_instr(in_instr),
        .flush(flush), .out_valid(aOutValid), .out_ready(out_ready), .rd(aRd), .rs1(aRs1),
        .rs2(aRs2), .imm(aImm), .use_imm(aUseImm), .alu_op(aAluOp), .reg_write(aRegWrite),
        .illegal(aIllegal), .illegal_count(aCount));

    decode_stage #(.ENABLE_ITYPE(0), .ENABLE_M(0), .CNT_W(CNT_W)) dutB (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(bInReady), .in_instr(in_instr),
        .flush(flush), .out_valid(bOutValid), .out_ready(out_ready), .rd(bRd), .rs1(bRs1),
        .rs2(bRs2), .imm(bImm), .use_imm(bUseImm), .alu_op(bAluOp), .reg_write(bRegWrite),
        .illegal(bIllegal), .illegal_count(bCount));

    assign aBundle = {aIllegal, aRegWrite, aAluOp, aUseImm, aImm, aRd, aRs1, aRs2};
    assign bBundle = {bIllegal, bRegWrite, bAluOp, bUseImm, bImm, bRd, bRs1, bRs2};

    function automatic logic [31:0] mkInstr(input logic [6:0] f7, input logic [4:0] r2,
                                            input logic [4:0] r1, input logic [2:0] f3,
                                            input logic [4:0] d, input logic [6:0] opc);
        return {f7, r2, r1, f3, d, opc};
    endfunction

    // Reference decode straight from the instruction-set rules
    function automatic logic [54:0] refDecode(input logic [31:0] ins, input bit enI, input bit enM);
        int op = -1;
        bit ui = 0;
        logic [31:0] im = 32'd0;
        logic [6:0] f7 = ins[31:25];
        int f3 = int'(ins[14:12]);
        if (ins[6:0] == 7'h33) begin
            if (f7 == 7'h00) op = baseOps[f3];
            else if (f7 == 7'h20 && f3 == 0) op = 1;
            else if (f7 == 7'h20 && f3 == 5) op = 7;
            else if (f7 == 7'h01 && enM) op = 10 + f3;
        end else if (ins[6:0] == 7'h13 && enI) begin
            ui = 1;
            if (f3 == 1 || f3 == 5) begin
                im = 32'(ins[24:20]);
                if (f7 == 7'h00) op = (f3 == 1) ? 5 : 6;
                else if (f7 == 7'h20 && f3 == 5) op = 7;
            end else begin
                op = baseOps[f3];
                im = 32'(signed'(ins[31:20]));
            end
        end
        if (op < 0)
            return {1'b1, 1'b0, 5'd0, 1'b0, 32'd0, ins[11:7], ins[19:15], ins[24:20]};
        return {1'b0, 1'b1, 5'(op), ui, im, ins[11:7], ins[19:15], ins[24:20]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic checkOutput();
        check("a_in_ready", 64'(aInReady), 64'(q.size() < 2));
        check("b_in_ready", 64'(bInReady), 64'(q.size() < 2));
        check("a_out_valid", 64'(aOutValid), 64'(q.size() > 0));
        check("b_out_valid", 64'(bOutValid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("a_bundle", 64'(aBundle), 64'(refDecode(q[0], 1'b1, 1'b1)));
            check("b_bundle", 64'(bBundle), 64'(refDecode(q[0], 1'b0, 1'b0)));
        end
        check("a_count", 64'(aCount), 64'(cntA));
        check("b_count", 64'(bCount), 64'(cntB));
    endtask

    // Drive one cycle of inputs, advance the model, then check at the next falling edge
    task automatic applyStimulus(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
        bit acc, drn;
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        acc = v && (q.size() < 2);
        drn = (q.size() > 0) && ordy;
        if (fl) begin
            q.delete();
        end else begin
            if (drn) begin
                if (refDecode(q[0], 1'b1, 1'b1)[54] && cntA != CMAX) cntA++;
                if (refDecode(q[0], 1'b0, 1'b0)[54] && cntB != CMAX) cntB++;
                void'(q.pop_front());
            end
            if (acc) q.push_back(ins);
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] r = $urandom;
        logic [6:0] f7s[4] = '{7'h00, 7'h20, 7'h01, 7'h7F};
        case ($urandom_range(0, 5))
            0, 1, 2: r[6:0] = 7'h33;
            3, 4:    r[6:0] = 7'h13;
            default: ;
        endcase
        if ($urandom_range(0, 3) != 0) r[31:25] = f7s[$urandom_range(0, 3)];
        return r;
    endfunction

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_ADDI = 32'hFFF00293;
    localparam logic [31:0] I_SRAI = 32'h4040D093;
    localparam logic [31:0] I_MUL  = 32'h023100B3;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    initial begin
        logic [31:0] i1, i2, i3;
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
        cntA = '0; cntB = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(aOutValid), 64'd0);
        check("rst_bundle", 64'(aBundle), 64'd0);
        check("rst_count", 64'(aCount), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(aInReady), 64'd1);

        applyStimulus(1, I_ADD, 1, 0);
        check("add_rd", 64'(aRd), 64'd3);
        check("add_rs1", 64'(aRs1), 64'd1);
        check("add_rs2", 64'(aRs2), 64'd2);
        check("add_op", 64'(aAluOp), 64'd0);
        check("add_wr", 64'(aRegWrite), 64'd1);
        check("add_useimm", 64'(aUseImm), 64'd0);
        applyStimulus(1, I_ADDI, 1, 0);
        check("addi_imm", 64'(aImm), 64'hFFFFFFFF);
        check("addi_useimm", 64'(aUseImm), 64'd1);
        check("addi_b_illegal", 64'(bIllegal), 64'd1);
        applyStimulus(1, I_SRAI, 1, 0);
        check("srai_op", 64'(aAluOp), 64'd7);
        check("srai_imm", 64'(aImm), 64'd4);
        applyStimulus(1, I_MUL, 1, 0);
        check("mul_a_op", 64'(aAluOp), 64'd10);
        check("mul_a_illegal", 64'(aIllegal), 64'd0);
        check("mul_b_illegal", 64'(bIllegal), 64'd1);
        check("mul_b_wr", 64'(bRegWrite), 64'd0);
        check("mul_b_cnt_before", 64'(bCount), 64'd2);
        applyStimulus(0, '0, 1, 0);
        check("mul_b_cnt_after", 64'(bCount), 64'd3);

        i1 = mkInstr(7'h00, 5'd2, 5'd1, 3'd0, 5'd10, 7'h33);
        i2 = mkInstr(7'h20, 5'd4, 5'd3, 3'd0, 5'd11, 7'h33);
        i3 = mkInstr(7'h00, 5'd6, 5'd5, 3'd7, 5'd12, 7'h33);
        applyStimulus(1, i1, 0, 0);
        check("bp_first", 64'(aRd), 64'd10);
        applyStimulus(1, i2, 0, 0);
        check("bp_hold", 64'(aRd), 64'd10);
        check("bp_skid_full", 64'(aInReady), 64'd0);
        applyStimulus(1, i3, 0, 0);
        check("bp_hold2", 64'(aRd), 64'd10);
        check("bp_blocked", 64'(aInReady), 64'd0);
        applyStimulus(1, i3, 1, 0);
        check("bp_second", 64'(aRd), 64'd11);
        applyStimulus(1, i3, 1, 0);
        check("bp_third", 64'(aRd), 64'd12);
        applyStimulus(0, '0, 1, 0);
        check("bp_empty", 64'(aOutValid), 64'd0);

        applyStimulus(1, I_BAD, 0, 0);
        applyStimulus(1, I_BAD, 0, 0);
        check("fl_full", 64'(aInReady), 64'd0);
        applyStimulus(1, I_ADD, 1, 1);
        check("fl_valid", 64'(aOutValid), 64'd0);
        check("fl_ready", 64'(aInReady), 64'd1);
        check("fl_cnt_a", 64'(aCount), 64'd0);
        check("fl_cnt_b", 64'(bCount), 64'd3);
        applyStimulus(1, I_ADD, 1, 1);
        check("fl_discard", 64'(aOutValid), 64'd0);

        applyStimulus(1, I_BAD, 1, 0);
        applyStimulus(1, I_BAD, 0, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(aOutValid), 64'd0);
        check("arst_cnt_a", 64'(aCount), 64'd0);
        check("arst_cnt_b", 64'(bCount), 64'd0);
        q.delete();
        cntA = '0; cntB = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput();

        for (int n = 0; n < 400; n++)
            applyStimulus($urandom_range(0, 3) != 0, randInstr(),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);

        for (int n = 0; n < (1 << CNT_W) + 3; n++)
            applyStimulus(1, I_BAD, 1, 0);
        applyStimulus(0, '0, 1, 0);
        check("sat_a", 64'(aCount), 64'(CMAX));
        check("sat_b", 64'(bCount), 64'(CMAX));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
